// File: rtl/imem_responder.sv
// ----------------------------------------------------------------------------
// imem_responder
//
// Memory-side end of the instruction fetch interface. Accepts one word-aligned
// fetch address at a time on a valid/ready request channel, looks the word up
// in an internal array and, after a fixed number of wait cycles, presents the
// instruction plus a fault flag on a valid/ready response channel. A side
// write port fills the array (boot loader / testbench).
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words in the array (power of two, >= 4)
//   LATENCY      wait cycles between request acceptance and response (0..15)
//   NOP_INST     instruction returned for a faulting fetch
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   req_valid_i    fetch request present
//   req_ready_o    responder can accept a request
//   req_addr_i     byte address of the fetch (PC)
//   resp_valid_o   response present
//   resp_ready_i   fetch side consumes the response
//   resp_inst_o    fetched instruction
//   resp_fault_o   misaligned or out-of-range fetch
//   prog_we_i      array write strobe
//   prog_addr_i    byte address of the write (bits [1:0] ignored)
//   prog_data_i    write data
// ----------------------------------------------------------------------------
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] NOP_INST    = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_inst_o,
    output logic        resp_fault_o,
    input  logic        prog_we_i,
    input  logic [31:0] prog_addr_i,
    input  logic [31:0] prog_data_i
);

    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] inst_q, inst_d;
    logic        fault_q, fault_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          req_fault;
    logic [AW-1:0] req_idx;
    logic          prog_in_range;
    logic [AW-1:0] prog_idx;
    logic          prog_unused;

    // Address decode: word index plus range/alignment checks.
    assign req_idx       = req_addr_i[AW+1:2];
    assign req_fault     = (req_addr_i[1:0] != 2'b00) ||
                           ({2'b00, req_addr_i[31:2]} >= DEPTH_WORDS);
    assign prog_idx      = prog_addr_i[AW+1:2];
    assign prog_in_range = ({2'b00, prog_addr_i[31:2]} < DEPTH_WORDS);
    // Byte-offset bits of a write address carry no meaning.
    assign prog_unused   = ^prog_addr_i[1:0];

    assign accept = req_valid_i & req_ready_o;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            inst_q  <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LAT == 4'd0) begin
                        state_d = S_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            S_WAIT: begin
                // Leaving on count 1 puts the response in the (LATENCY+1)th
                // cycle after acceptance.
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response data is captured only at acceptance, so later writes to the
    // array cannot disturb a pending response. The array read happens before
    // any same-edge write lands, giving read-before-write behaviour.
    always_comb begin
        inst_d  = inst_q;
        fault_d = fault_q;
        if (accept) begin
            inst_d  = req_fault ? NOP_INST : mem[req_idx];
            fault_d = req_fault;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        req_ready_o  = (state_q == S_IDLE) && !rst_i;
        resp_valid_o = (state_q == S_RESP);
        resp_inst_o  = inst_q;
        resp_fault_o = fault_q;
    end

    // Word array: no reset, writes allowed in every state, out-of-range
    // writes dropped.
    always_ff @(posedge clk_i) begin
        if (prog_we_i && prog_in_range) begin
            mem[prog_idx] <= prog_data_i;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] W0  = 32'h00500093;
    localparam logic [31:0] W1  = 32'h00A00113;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;

    // Index 0: LATENCY=2 build, index 1: LATENCY=0 build.
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] req_addr   [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_inst  [2];
    logic        resp_fault [2];

    int checks = 0;
    int errors = 0;

    imem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .NOP_INST(NOP)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
        .resp_inst_o(resp_inst[0]), .resp_fault_o(resp_fault[0]),
        .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data)
    );

    imem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .NOP_INST(NOP)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
        .resp_inst_o(resp_inst[1]), .resp_fault_o(resp_fault[1]),
        .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = addr; prog_data = data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Single fetch on the LATENCY=2 build with resp_ready held high.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_inst,
                         input logic exp_fault, input string nm);
        @(negedge clk);
        req_valid[0] = 1'b1; req_addr[0] = addr; resp_ready[0] = 1'b1;
        checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL %s_ready_idle got %b want 1", nm, req_ready[0]); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req_valid[0] = 1'b0;
            checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL %s_ready_busy c%0d got %b want 0", nm, c, req_ready[0]); end
            checks++; if (resp_valid[0] !== (c == 3)) begin errors++; $display("FAIL %s_valid c%0d got %b want %b", nm, c, resp_valid[0], c == 3); end
            if (c == 3) begin
                checks++; if (resp_inst[0] !== exp_inst) begin errors++; $display("FAIL %s_inst got %h want %h", nm, resp_inst[0], exp_inst); end
                checks++; if (resp_fault[0] !== exp_fault) begin errors++; $display("FAIL %s_fault got %b want %b", nm, resp_fault[0], exp_fault); end
            end
        end
        @(negedge clk);
        checks++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL %s_valid_after got %b want 0", nm, resp_valid[0]); end
        checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL %s_ready_after got %b want 1", nm, req_ready[0]); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++; if (req_ready[d] !== 1'b0) begin errors++; $display("FAIL rst_ready%0d got %b want 0", d, req_ready[d]); end
            checks++; if (resp_valid[d] !== 1'b0) begin errors++; $display("FAIL rst_valid%0d got %b want 0", d, resp_valid[d]); end
            checks++; if (resp_inst[d] !== 32'd0) begin errors++; $display("FAIL rst_inst%0d got %h want 0", d, resp_inst[d]); end
            checks++; if (resp_fault[d] !== 1'b0) begin errors++; $display("FAIL rst_fault%0d got %b want 0", d, resp_fault[d]); end
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL rst_release_ready%0d got %b want 1", d, req_ready[d]); end
        end
    endtask

    task automatic test_basic_fetch();
        write_word(32'h0, W0);
        write_word(32'h4, W1);
        fetch(32'h0, W0, 1'b0, "basic0");
        fetch(32'h4, W1, 1'b0, "basic1");
    endtask

    task automatic test_fault();
        fetch(32'h2,    NOP, 1'b1, "misalign");
        fetch(32'h1000, NOP, 1'b1, "range");
        fetch(32'h0,    W0,  1'b0, "post_fault");
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_valid[0] = 1'b1; req_addr[0] = 32'h0; resp_ready[0] = 1'b0;
        checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_idle got %b want 1", req_ready[0]); end
        @(negedge clk);
        req_addr[0] = 32'h4;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            checks++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_wait_valid c%0d got %b want 0", c, resp_valid[0]); end
            checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_wait_ready c%0d got %b want 0", c, req_ready[0]); end
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (resp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_stall_valid c%0d got %b want 1", c, resp_valid[0]); end
            checks++; if (resp_inst[0] !== W0) begin errors++; $display("FAIL bp_stall_inst c%0d got %h want %h", c, resp_inst[0], W0); end
            checks++; if (resp_fault[0] !== 1'b0) begin errors++; $display("FAIL bp_stall_fault c%0d got %b want 0", c, resp_fault[0]); end
            checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_stall_ready c%0d got %b want 0", c, req_ready[0]); end
        end
        resp_ready[0] = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_hs_valid got %b want 0", resp_valid[0]); end
        checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_hs_ready got %b want 1", req_ready[0]); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_second_accept got %b want 0", req_ready[0]); end
        @(negedge clk);
        checks++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_second_wait got %b want 0", resp_valid[0]); end
        @(negedge clk);
        checks++; if (resp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %b want 1", resp_valid[0]); end
        checks++; if (resp_inst[0] !== W1) begin errors++; $display("FAIL bp_second_inst got %h want %h", resp_inst[0], W1); end
        @(negedge clk);
        checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_end_ready got %b want 1", req_ready[0]); end
    endtask

    task automatic test_read_before_write();
        write_word(32'hC, 32'hAAAAAAAA);
        @(negedge clk);
        req_valid[0] = 1'b1; req_addr[0] = 32'hC; resp_ready[0] = 1'b1;
        prog_we = 1'b1; prog_addr = 32'hC; prog_data = 32'h55555555;
        @(negedge clk);
        req_valid[0] = 1'b0; prog_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (resp_valid[0] !== 1'b1) begin errors++; $display("FAIL rbw_valid got %b want 1", resp_valid[0]); end
        checks++; if (resp_inst[0] !== 32'hAAAAAAAA) begin errors++; $display("FAIL rbw_old got %h want aaaaaaaa", resp_inst[0]); end
        @(negedge clk);
        fetch(32'hC, 32'h55555555, 1'b0, "rbw_refetch");
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        req_valid[0] = 1'b1; req_addr[0] = 32'h4; resp_ready[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL rmw_ready_in_rst got %b want 0", req_ready[0]); end
        checks++; if (resp_inst[0] !== 32'd0) begin errors++; $display("FAIL rmw_inst_cleared got %h want 0", resp_inst[0]); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL rmw_ready_after got %b want 1", req_ready[0]); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL rmw_no_resp c%0d got %b want 0", c, resp_valid[0]); end
        end
    endtask

    task automatic test_latency0_back_to_back();
        @(negedge clk);
        req_valid[1] = 1'b1; req_addr[1] = 32'h0; resp_ready[1] = 1'b1;
        checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL l0_ready0 got %b want 1", req_ready[1]); end
        @(negedge clk);
        req_addr[1] = 32'h4;
        checks++; if (resp_valid[1] !== 1'b1) begin errors++; $display("FAIL l0_valid0 got %b want 1", resp_valid[1]); end
        checks++; if (resp_inst[1] !== W0) begin errors++; $display("FAIL l0_inst0 got %h want %h", resp_inst[1], W0); end
        checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL l0_busy0 got %b want 0", req_ready[1]); end
        @(negedge clk);
        checks++; if (resp_valid[1] !== 1'b0) begin errors++; $display("FAIL l0_gap got %b want 0", resp_valid[1]); end
        checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL l0_ready1 got %b want 1", req_ready[1]); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        checks++; if (resp_valid[1] !== 1'b1) begin errors++; $display("FAIL l0_valid1 got %b want 1", resp_valid[1]); end
        checks++; if (resp_inst[1] !== W1) begin errors++; $display("FAIL l0_inst1 got %h want %h", resp_inst[1], W1); end
        checks++; if (resp_fault[1] !== 1'b0) begin errors++; $display("FAIL l0_fault1 got %b want 0", resp_fault[1]); end
        @(negedge clk);
        checks++; if (resp_valid[1] !== 1'b0) begin errors++; $display("FAIL l0_end got %b want 0", resp_valid[1]); end
    endtask

    initial begin
        rst = 1'b1;
        prog_we = 1'b0; prog_addr = 32'd0; prog_data = 32'd0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_addr[d] = 32'd0; resp_ready[d] = 1'b0;
        end
        test_reset();
        test_basic_fetch();
        test_fault();
        test_backpressure();
        test_read_before_write();
        test_reset_mid_wait();
        test_latency0_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
